dcp_dispatch_unit: RTL
======================

Name: dcp_dispatch_unit

Overview:
- 1-to-SNUM dispatcher for the Decoupled (Vld/Rdy/Data) protocol. It is the inverse of the N-to-1 switch unit.
- Accepts packets on one input stream and routes each packet to the output port named by its head beat. The route stays locked until the Last beat.
- Registered output stage: 1-cycle latency, full throughput.
- Packets whose destination is out of range are consumed, discarded and counted.

Parameters:
- DW, 8, payload width in bits.
- SNUM, 4, number of output ports (at least 2; need not be a power of 2).
- DSTW, $clog2(SNUM), destination field width (derived, localparam).
- CNTW, 16, drop-counter width.

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iDcpIn_Vld  in  1  input beat valid.
- iDcpIn_Rdy  out  1  input beat ready.
- iDcpIn_Data  in  DW  input payload.
- iDcpIn_Dst  in  DSTW  destination port; sampled on head beat only.
- iDcpIn_Last  in  1  last beat of packet.
- oDcpOut_Vld  out  SNUM  per-port valid.
- oDcpOut_Rdy  in  SNUM  per-port ready.
- oDcpOut_Data  out  DW  payload, shared by all ports.
- oDcpOut_Last  out  1  last flag, shared.
- oDropCnt  out  CNTW  count of dropped packets, saturating.

Behaviour:
- Handshake: a beat transfers when Vld && Rdy on a rising edge.
  - Vld must not depend on Rdy.
  - Once Vld is asserted, Data/Dst/Last are held stable until the transfer.
- Reset (async assert, sync release):
  - state=IDLE, hold register empty, all oDcpOut_Vld=0, oDcpOut_Data=0, oDcpOut_Last=0, oDropCnt=0.
  - Reset mid-packet abandons the packet. The next accepted beat is treated as a head beat.
- Hold register: holdVld, holdPort, holdData, holdLast.
  - oDcpOut_Vld[k] = holdVld && (holdPort==k). All other bits are 0.
  - drain = holdVld && oDcpOut_Rdy[holdPort].
  - Data/Last stay stable while held.
- dstOk = (iDcpIn_Dst < SNUM).
- FSM states: IDLE (expect head), FWD (route locked to lockPort), DROP (discarding).
- iDcpIn_Rdy:
  - DROP: 1.
  - IDLE && !dstOk: 1.
  - Otherwise: !holdVld || drain (simultaneous drain and load is allowed: full rate).
- IDLE, accepted beat:
  - dstOk: load hold register with port=Dst. If !Last, go to FWD with lockPort=Dst.
  - !dstOk: oDropCnt+=1 (saturate at all-ones). If !Last, go to DROP. The beat never appears on any output.
- FWD, accepted beat:
  - Load hold register with port=lockPort. Dst is ignored.
  - Last returns the FSM to IDLE.
- DROP, accepted beat: discard. Last returns the FSM to IDLE.
- Latency: an accepted beat is visible on its oDcpOut_Vld bit the next cycle.
- Sustained 1 beat/cycle when the target port holds Rdy=1.
- Backpressure on the locked port stalls the input only. Other ports never see Vld.
- Single-beat packet (head with Last=1): FSM stays in IDLE.
- Back-to-back packets to different ports need no bubble.
- oDcpOut_Rdy bits of non-selected ports are ignored.
- Counter at max stays at max. No wrap.

Decomposition:
- Shared package dcp_pkg holds:
  - the state enum (DISP_IDLE, DISP_FWD, DISP_DROP);
  - a function clog2_min1 so DSTW is at least 1.
- Sub-module dcp_hold_reg: 1-entry register slice with load/drain, parameterized on payload width (DW+1+DSTW). Reusable by the switch unit.

Test Plan:
1. Reset then single-beat packet Data=0x5A, Dst=2, Last=1, all out Rdy=1.
   - Next cycle oDcpOut_Vld=4'b0100, Data=0x5A, Last=1.
   - Then Vld=0. oDropCnt=0.
2. 4-beat packet 0x10..0x13, Dst=1 on head, Dst=3 on beats 2-4, Rdy=1.
   - All 4 beats appear on port 1 only, on consecutive cycles. Last asserts with 0x13.
3. Same packet with oDcpOut_Rdy[1] toggling 1,0,0,1,...:
   - iDcpIn_Rdy deasserts while port 1 is stalled;
   - beats stay in order with no loss or duplication;
   - oDcpOut_Data is stable while Vld=1 and Rdy=0.
4. SNUM=3 build, head Dst=3 with a 3-beat packet, followed by a 1-beat packet to Dst=0.
   - iDcpIn_Rdy=1 for all 3 dropped beats; no output Vld for them.
   - oDropCnt=1; the next packet arrives on port 0.
5. Back-to-back single-beat packets to ports 0,1,2,3,0 with no input gaps.
   - Output Vld one-hot sequence 0001, 0010, 0100, 1000, 0001 on 5 consecutive cycles.
6. Assert iRst mid-packet after beat 2 of 4 to port 2.
   - Outputs clear immediately.
   - After release, a head beat with Dst=0 routes to port 0, not port 2.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared types and helpers for the decoupled-protocol dispatch/switch units.
package dcp_pkg;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_FWD,
        DISP_DROP
    } disp_state_e;

    // A one-port or two-port build still needs a 1-bit destination field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dcp_dispatch_unit_if.sv
// Input stream plus fan-out stream bundle seen by the dispatcher.
interface dcp_dispatch_unit_if
    import dcp_pkg::*;
#(
    parameter int DW   = 8,
    parameter int SNUM = 4,
    parameter int CNTW = 16
);
    localparam int DSTW = clog2_min1(SNUM);

    logic            iDcpIn_Vld;
    logic            iDcpIn_Rdy;
    logic [DW-1:0]   iDcpIn_Data;
    logic [DSTW-1:0] iDcpIn_Dst;
    logic            iDcpIn_Last;
    logic [SNUM-1:0] oDcpOut_Vld;
    logic [SNUM-1:0] oDcpOut_Rdy;
    logic [DW-1:0]   oDcpOut_Data;
    logic            oDcpOut_Last;
    logic [CNTW-1:0] oDropCnt;

    modport slave (
        input  iDcpIn_Vld, iDcpIn_Data, iDcpIn_Dst, iDcpIn_Last, oDcpOut_Rdy,
        output iDcpIn_Rdy, oDcpOut_Vld, oDcpOut_Data, oDcpOut_Last, oDropCnt
    );

    modport master (
        output iDcpIn_Vld, iDcpIn_Data, iDcpIn_Dst, iDcpIn_Last, oDcpOut_Rdy,
        input  iDcpIn_Rdy, oDcpOut_Vld, oDcpOut_Data, oDcpOut_Last, oDropCnt
    );

endinterface

// File: rtl/dcp_hold_reg.sv
// One-entry register slice; a load wins over a drain in the same cycle.
module dcp_hold_reg #(
    parameter int W = 8
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q;
    logic [W-1:0] data_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            data_q <= data_i;
        end else if (drain_i) begin
            vld_q  <= 1'b0;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/dcp_dispatch_unit.sv
// 1-to-SNUM packet dispatcher: head beat picks the port, route locked until Last.
module dcp_dispatch_unit
    import dcp_pkg::*;
#(
    parameter int DW   = 8,
    parameter int SNUM = 4,
    parameter int CNTW = 16
) (
    input logic                iClk,
    input logic                iRst,
    dcp_dispatch_unit_if.slave dcp
);
    localparam int DSTW = clog2_min1(SNUM);
    localparam int HW   = DSTW + 1 + DW;

    disp_state_e     state_q, state_d;
    logic [DSTW-1:0] lock_q, lock_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            hold_vld;
    logic [HW-1:0]   hold_pay;
    logic [DSTW-1:0] hold_port;
    logic            load;
    logic [DSTW-1:0] load_port;
    logic            drain;
    logic            in_rdy;
    logic            accept;
    logic            dst_ok;

    dcp_hold_reg #(.W(HW)) u_hold (
        .iClk    (iClk),
        .iRst    (iRst),
        .load_i  (load),
        .drain_i (drain),
        .data_i  ({load_port, dcp.iDcpIn_Last, dcp.iDcpIn_Data}),
        .vld_o   (hold_vld),
        .data_o  (hold_pay)
    );

    assign hold_port        = hold_pay[HW-1 -: DSTW];
    assign dcp.oDcpOut_Last = hold_pay[DW];
    assign dcp.oDcpOut_Data = hold_pay[DW-1:0];

    for (genvar gi = 0; gi < SNUM; gi++) begin : g_vld
        assign dcp.oDcpOut_Vld[gi] = hold_vld && (hold_port == DSTW'(gi));
    end

    // Only the selected port's ready can matter since at most one Vld bit is set.
    assign drain  = |(dcp.oDcpOut_Vld & dcp.oDcpOut_Rdy);
    assign dst_ok = ({1'b0, dcp.iDcpIn_Dst} < (DSTW+1)'(SNUM));
    assign accept = dcp.iDcpIn_Vld && in_rdy;
    assign dcp.iDcpIn_Rdy = in_rdy;
    assign dcp.oDropCnt   = cnt_q;

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_port = lock_q;
        in_rdy    = !hold_vld || drain;
        unique case (state_q)
            DISP_IDLE: begin
                if (!dst_ok) in_rdy = 1'b1;
                if (accept) begin
                    if (dst_ok) begin
                        load      = 1'b1;
                        load_port = dcp.iDcpIn_Dst;
                        if (!dcp.iDcpIn_Last) begin
                            state_d = DISP_FWD;
                            lock_d  = dcp.iDcpIn_Dst;
                        end
                    end else begin
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
                        if (!dcp.iDcpIn_Last) state_d = DISP_DROP;
                    end
                end
            end
            DISP_FWD: begin
                if (accept) begin
                    load = 1'b1;
                    if (dcp.iDcpIn_Last) state_d = DISP_IDLE;
                end
            end
            DISP_DROP: begin
                in_rdy = 1'b1;
                if (accept && dcp.iDcpIn_Last) state_d = DISP_IDLE;
            end
            default: state_d = DISP_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= DISP_IDLE;
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
